// File: rtl/fifo_reader_pkg.sv
// ============================================================================
// Module : fifo_reader_pkg
// Brief  : Shared types and default widths for the FIFO burst reader.
//          state_t    - burst controller states
//          DATA_WIDTH - default FIFO / stream data width
//          LEN_WIDTH  - default burst length / counter width
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_reader_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stream_out_stage.sv
// ============================================================================
// Module : stream_out_stage
// Brief  : Single-entry registered valid/ready slice carrying data + last.
// Ports  : clk, rst         - clock, synchronous active-low reset
//          load             - capture load_data/load_last this edge
//          load_data        - word to capture
//          load_last        - last marker to capture
//          ready            - downstream accept
//          valid/data/last  - registered stream outputs
//          can_accept       - slot is free now or frees on this edge
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_out_stage #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DataWidth-1:0] load_data,
  input  logic                 load_last,
  input  logic                 ready,
  output logic                 valid,
  output logic [DataWidth-1:0] data,
  output logic                 last,
  output logic                 can_accept
);

  // A full slot whose word is being taken this cycle can be refilled on the
  // same edge, which is what sustains one word per cycle.
  assign can_accept = !valid || ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (valid && ready) begin
      // Data is left in place; only the qualifiers drop.
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module : fifo_burst_reader
// Brief  : Pops exactly burstLen words from a fall-through FIFO on start and
//          forwards them on a registered valid/ready stream with a last
//          marker; a one-cycle done pulse closes each burst.
// Ports  : clk, rst                   - clock, synchronous active-low reset
//          start, burstLen            - burst request (sampled in IDLE only)
//          busy, done                 - status (registered)
//          fifoReadEn                 - FIFO pop strobe (combinational)
//          fifoReadData, fifoEmpty    - FIFO head word and empty flag
//          outValid, outData, outLast - registered stream outputs
//          outReady                   - downstream accept
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int LenWidth  = LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LenWidth-1:0]  burstLen,
  output logic                 busy,
  output logic                 done,
  output logic                 fifoReadEn,
  input  logic [DataWidth-1:0] fifoReadData,
  input  logic                 fifoEmpty,
  output logic                 outValid,
  output logic [DataWidth-1:0] outData,
  output logic                 outLast,
  input  logic                 outReady
);

  state_t              state;
  logic [LenWidth-1:0] remaining;
  logic                can_accept;
  logic                pop;
  logic                last_pop;

  // Gating with rst keeps the strobe low during reset even before the state
  // register has been cleared.
  assign pop        = rst && (state == READ) && (remaining != '0) &&
                      !fifoEmpty && can_accept;
  assign fifoReadEn = pop;
  assign last_pop   = (remaining == LenWidth'(1));

  stream_out_stage #(
    .DataWidth (DataWidth)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .load       (pop),
    .load_data  (fifoReadData),
    .load_last  (last_pop),
    .ready      (outReady),
    .valid      (outValid),
    .data       (outData),
    .last       (outLast),
    .can_accept (can_accept)
  );

  // busy and done are registered alongside the state so they are exact
  // decodes of the state the FSM is in during each cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (burstLen != '0) begin
              remaining <= burstLen;
              state     <= READ;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (pop) begin
            remaining <= remaining - LenWidth'(1);
            if (last_pop) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // can_accept covers both "last word leaves on this edge" and
          // "slot already empty".
          if (can_accept) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module : tb_fifo_burst_reader
// Brief  : Self-checking bench for fifo_burst_reader. A queue stands in for
//          the FIFO; words handed over on each pop form the expected output
//          order, and burst-level counts (pops, accepted words, done pulses)
//          are checked against the requested length.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  burstLen;
  logic        busy;
  logic        done;
  logic        fifoReadEn;
  logic [31:0] fifoReadData;
  logic        fifoEmpty;
  logic        outValid;
  logic [31:0] outData;
  logic        outLast;
  logic        outReady;

  int checks = 0;
  int errors = 0;

  logic [31:0] fq[$];     // FIFO contents
  logic [31:0] exp_q[$];  // words popped and not yet delivered
  logic [15:0] ren_vec, ov_vec, last_vec, done_vec, busy_vec;

  fifo_burst_reader #(
    .DataWidth (32),
    .LenWidth  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .burstLen     (burstLen),
    .busy         (busy),
    .done         (done),
    .fifoReadEn   (fifoReadEn),
    .fifoReadData (fifoReadData),
    .fifoEmpty    (fifoEmpty),
    .outValid     (outValid),
    .outData      (outData),
    .outLast      (outLast),
    .outReady     (outReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fifo_drive();
    fifoEmpty = (fq.size() == 0);
    if (fifoEmpty) fifoReadData = $urandom;
    else           fifoReadData = fq[0];
  endtask

  // mode 0: ready=1            mode 1: FIFO fed at cycles 5,7,9
  // mode 2: ready from cyc 6   mode 3: random feed and ready
  // mode 4: start re-pulsed    mode 5: reset at cycle 3
  task automatic run(input int len, input int mode, input int maxcyc);
    int   cyc = 0, pops = 0, accepts = 0, done_cnt = 0, done_at = -1;
    bit   ren, hold = 0, rst_cyc, timed_out = 0;
    logic [31:0] pdata = '0;
    logic        plast = 1'b0;
    ren_vec = '0; ov_vec = '0; last_vec = '0; done_vec = '0; busy_vec = '0;
    while (1) begin
      start    = (cyc == 0) || (mode == 4 && cyc == 2);
      burstLen = (cyc == 0) ? 8'(len) : 8'd7;
      if (mode == 2)      outReady = (cyc >= 6);
      else if (mode == 3) outReady = 1'($urandom_range(0, 1));
      else                outReady = 1'b1;
      rst = !(mode == 5 && cyc == 3);
      if (mode == 1 && (cyc == 5 || cyc == 7 || cyc == 9)) fq.push_back($urandom);
      if (mode == 3 && $urandom_range(0, 1) == 1) fq.push_back($urandom);
      fifo_drive();

      @(negedge clk);
      chk("ren_while_empty", 32'(fifoReadEn && fifoEmpty), 0);
      if (!rst) chk("ren_in_reset", 32'(fifoReadEn), 0);
      if (hold) begin
        chk("hold_valid", 32'(outValid), 1);
        chk("hold_data", outData, pdata);
        chk("hold_last", 32'(outLast), 32'(plast));
      end
      if (outValid && outReady) begin
        chk("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("out_data", outData, exp_q.pop_front());
        chk("out_last", 32'(outLast), 32'(accepts == len - 1));
        accepts++;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
        chk("busy_in_done", 32'(busy), 1);
      end
      if (cyc < 16) begin
        ren_vec[cyc[3:0]]  = fifoReadEn;
        ov_vec[cyc[3:0]]   = outValid;
        last_vec[cyc[3:0]] = outLast;
        done_vec[cyc[3:0]] = done;
        busy_vec[cyc[3:0]] = busy;
      end
      if (done_at >= 0 && cyc == done_at + 1) begin
        chk("busy_after_done", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
      end
      if (mode == 5 && cyc == 4) begin
        chk("rst_outValid", 32'(outValid), 0);
        chk("rst_outLast", 32'(outLast), 0);
        chk("rst_outData", outData, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ren", 32'(fifoReadEn), 0);
      end
      ren     = fifoReadEn;
      hold    = outValid && !outReady && rst;
      pdata   = outData;
      plast   = outLast;
      rst_cyc = !rst;

      @(posedge clk); #1;
      if (ren && fq.size() != 0) begin
        exp_q.push_back(fq.pop_front());
        pops++;
      end
      if (rst_cyc) exp_q.delete();
      if (done_at >= 0 && cyc == done_at + 1) break;
      if (mode == 5 && cyc == 4) break;
      if (cyc >= maxcyc) begin
        timed_out = 1;
        break;
      end
      cyc++;
    end
    start    = 1'b0;
    rst      = 1'b1;
    outReady = 1'b1;
    fifo_drive();
    chk("timeout", 32'(timed_out), 0);
    if (mode == 5) begin
      chk("no_done_after_reset", 32'(done_cnt), 0);
    end else begin
      chk("pop_count", 32'(pops), 32'(len));
      chk("word_count", 32'(accepts), 32'(len));
      chk("done_count", 32'(done_cnt), 1);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
    end
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    burstLen     = '0;
    outReady     = 1'b1;
    fifoEmpty    = 1'b0;
    fifoReadData = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outValid", 32'(outValid), 0);
    chk("reset_outLast", 32'(outLast), 0);
    chk("reset_outData", outData, 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_ren", 32'(fifoReadEn), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    fq.delete();
    fifo_drive();
    @(posedge clk); #1;

    // Four preloaded words, free-flowing downstream.
    fq.delete();
    for (int i = 0; i < 4; i++) fq.push_back(32'hA000_0000 + 32'(i));
    run(4, 0, 40);
    chk("t1_ren", 32'(ren_vec), 32'h001E);
    chk("t1_valid", 32'(ov_vec), 32'h003C);
    chk("t1_last", 32'(last_vec), 32'h0020);
    chk("t1_done", 32'(done_vec), 32'h0040);
    chk("t1_busy", 32'(busy_vec), 32'h007E);

    // Zero-length burst.
    run(0, 0, 10);
    chk("t2_ren", 32'(ren_vec), 0);
    chk("t2_done", 32'(done_vec), 32'h0002);
    chk("t2_busy", 32'(busy_vec), 32'h0002);
    chk("t2_valid", 32'(ov_vec), 0);

    // Empty FIFO, then trickle-fed.
    fq.delete();
    run(3, 1, 60);

    // Downstream back-pressure for four cycles.
    fq.delete();
    for (int i = 0; i < 3; i++) fq.push_back(32'hB000_0000 + 32'(i));
    run(3, 2, 60);
    chk("t4_ren", 32'(ren_vec), 32'h00C2);
    chk("t4_valid", 32'(ov_vec), 32'h01FC);
    chk("t4_last", 32'(last_vec), 32'h0100);
    chk("t4_done", 32'(done_vec), 32'h0200);
    chk("t4_busy", 32'(busy_vec), 32'h03FE);

    // Reset mid-burst, then a fresh burst from the words left behind.
    fq.delete();
    for (int i = 0; i < 4; i++) fq.push_back(32'hC000_0000 + 32'(i));
    run(4, 5, 20);
    chk("t5_ren", 32'(ren_vec), 32'h0006);
    chk("t5_fifo_left", 32'(fq.size()), 2);
    run(2, 0, 30);

    // Second start during READ is ignored.
    fq.delete();
    for (int i = 0; i < 10; i++) fq.push_back(32'hD000_0000 + 32'(i));
    run(3, 4, 40);
    chk("t6_fifo_left", 32'(fq.size()), 7);

    // Random lengths, random FIFO fill and random back-pressure.
    fq.delete();
    for (int n = 0; n < 20; n++) run(int'($urandom_range(0, 12)), 3, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Consumer-side controller for the FIFO read port. On a start command it pops exactly burstLen words from the FIFO. It honours empty, so the FIFO's no-read-when-empty rule always holds. Popped words are presented on a registered valid/ready stream with a last marker, and a one-cycle done pulse closes the burst. It sits between the FIFO and downstream consumers (DMA or packet egress).

Parameters:
DataWidth, 32, width of FIFO data and stream data
LenWidth, 8, width of burstLen and of the remaining-word counter; max burst is 2^LenWidth-1 words

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-low reset (rst==0 resets on a clk edge)
start  input  1  single-cycle burst request; sampled only in IDLE
burstLen  input  LenWidth  words to read; sampled with start
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse at burst completion
fifoReadEn  output  1  FIFO pop strobe; combinational
fifoReadData  input  DataWidth  FIFO head word, valid in the same cycle as a pop (fall-through)
fifoEmpty  input  1  FIFO empty flag
outValid  output  DataWidth-independent 1  stream data valid (registered)
outData  output  DataWidth  stream data (registered)
outLast  output  1  marks the final word of the burst; qualified by outValid
outReady  input  1  downstream accept

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, remaining=0.
  - outValid, outLast, done, busy = 0; outData = 0.
  - fifoReadEn = 0 whenever rst==0.
- States: IDLE, READ, DRAIN, DONE. State and remaining are held in flops.
- IDLE:
  - start with burstLen!=0: load remaining=burstLen, go to READ.
  - start with burstLen==0: go to DONE; no pops.
  - start is ignored in every other state.
- READ:
  - pop = (remaining!=0) && !fifoEmpty && (!outValid || outReady); fifoReadEn = pop.
  - On pop, next edge: outData<=fifoReadData, outValid<=1, outLast<=(remaining==1), remaining<=remaining-1.
  - When the pop takes remaining 1->0, go to DRAIN.
  - Output stage with no pop: if outValid && outReady, clear outValid and outLast; otherwise hold.
  - Throughput is one word per cycle when the FIFO is non-empty and outReady=1.
  - Latency: pop in cycle N gives outValid in cycle N+1.
  - fifoEmpty=1 stalls popping only; the output stage keeps draining.
- DRAIN:
  - fifoReadEn = 0.
  - Wait for outValid && outReady on the last word; on that edge clear outValid/outLast and go to DONE.
  - If outValid is already 0, go to DONE on the next edge.
- DONE: done=1 for exactly one cycle, then IDLE.
- fifoReadEn is never high when fifoEmpty=1, when remaining==0, or outside READ.
- Stream rule: while outValid && !outReady, outData and outLast stay stable and outValid stays 1.
- Reset mid-burst: the burst is abandoned, words already popped are discarded, and there is no done pulse.

Decomposition:
- Package fifo_reader_pkg:
  - state enum typedef {IDLE, READ, DRAIN, DONE}
  - default DATA_WIDTH / LEN_WIDTH constants
- One natural sub-module: stream_out_stage. It is the single-entry registered valid/ready slice holding data+last and exposes canAccept = !outValid || outReady.

Test Plan:
- 4 words A0..A3 preloaded, outReady=1, start with burstLen=4 at cycle 0 -> fifoReadEn cycles 1-4; outValid cycles 2-5 carrying A0..A3; outLast only at cycle 5; done at cycle 6; busy low from cycle 7.
- burstLen=0 with start -> no fifoReadEn; done=1 at cycle 1; busy cycle 1 only.
- burstLen=3, FIFO empty for 5 cycles then fed one word every other cycle -> fifoReadEn never high while fifoEmpty=1; exactly 3 words out, in order; done once.
- burstLen=3, outReady held 0 for 4 cycles after first outValid -> outData stable, no further pops; resumes 1 word/cycle after outReady rises.
- rst=0 asserted while remaining=2 -> next cycle all outputs 0 and state IDLE; no done; a new start with burstLen=2 completes normally.
- start pulsed again during READ with burstLen=7 -> ignored; the original burst count is unchanged.
